// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequences MULT/DIV/MTHI/MTLO requests from the
// multicycle control unit onto the external mult and div units, holds
// the run line until completion (or watchdog abort), and owns the
// architectural HI/LO registers.
// Optional build macro: HILO_FORWARD_EN -- forwards the incoming result
// onto hi_out/lo_out and raises done in the completion cycle itself.
module hilo_muldiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        timeout_err,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mult_ctrl,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_stop,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_ctrl,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic        div_zero,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MULT_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mult_a;
    logic [31:0] r_mult_b;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic        r_div0;
    logic        r_tmo;

    // Sequencer: state, watchdog, operand latches, HI/LO capture and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_mult_a <= 32'd0;
            r_mult_b <= 32'd0;
            r_div_a  <= 32'd0;
            r_div_b  <= 32'd0;
            r_div0   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= 8'd0;
                    r_div0 <= 1'b0;
                    r_tmo  <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                r_mult_a <= rs_val;
                                r_mult_b <= rt_val;
                                r_cnt    <= 8'd1;
                                r_state  <= S_MULT_RUN;
                            end
                            OP_DIV: begin
                                r_div_a <= rs_val;
                                r_div_b <= rt_val;
                                r_cnt   <= 8'd1;
                                r_state <= S_DIV_RUN;
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_MULT_RUN: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (mult_stop) begin
                        r_hi    <= mult_hi;
                        r_lo    <= mult_lo;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DIV_RUN: begin
                    if (div_done) begin
                        if (div_zero) begin
                            r_div0 <= 1'b1;
                        end else begin
                            r_hi <= div_hi;
                            r_lo <= div_lo;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // One guaranteed ctrl-low cycle so the responder re-arms.
                    r_cnt   <= 8'd0;
                    r_div0  <= 1'b0;
                    r_tmo   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mult_ctrl   = (r_state == S_MULT_RUN);
    assign div_ctrl    = (r_state == S_DIV_RUN);
    assign mult_a      = r_mult_a;
    assign mult_b      = r_mult_b;
    assign div_a       = r_div_a;
    assign div_b       = r_div_b;
    assign div0_exc    = r_div0;
    assign timeout_err = r_tmo;

`ifdef HILO_FORWARD_EN
    logic        w_fwd;
    logic [31:0] w_fwd_hi;
    logic [31:0] w_fwd_lo;

    // A successful completion is visible in the same cycle it is reported.
    assign w_fwd    = ((r_state == S_MULT_RUN) && mult_stop) ||
                      ((r_state == S_DIV_RUN) && div_done && !div_zero);
    assign w_fwd_hi = (r_state == S_MULT_RUN) ? mult_hi : div_hi;
    assign w_fwd_lo = (r_state == S_MULT_RUN) ? mult_lo : div_lo;
    assign hi_out   = w_fwd ? w_fwd_hi : r_hi;
    assign lo_out   = w_fwd ? w_fwd_lo : r_lo;
    assign done     = w_fwd || ((r_state == S_DONE) && (r_div0 || r_tmo));
    assign busy     = (r_state == S_MULT_RUN) || (r_state == S_DIV_RUN);
`else
    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign done   = (r_state == S_DONE);
    assign busy   = (r_state != S_IDLE);
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: stimulus pushes the expected
// HI/LO/flag result of every MULT/DIV; a monitor pops and compares on done.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div0_exc, timeout_err;
    logic [31:0] hi_out, lo_out;
    logic        mult_ctrl, div_ctrl;
    logic [31:0] mult_a, mult_b, div_a, div_b;
    logic        mult_stop, div_done, div_zero;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        t;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hilo_muldiv_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .div0_exc(div0_exc), .timeout_err(timeout_err),
        .hi_out(hi_out), .lo_out(lo_out),
        .mult_ctrl(mult_ctrl), .mult_a(mult_a), .mult_b(mult_b),
        .mult_stop(mult_stop), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_ctrl(div_ctrl), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((div0_exc || timeout_err) && !done) begin
                n_checks++;
                n_errors++;
                $display("FAIL err_without_done: got div0=%b tmo=%b expected done=1", div0_exc, timeout_err);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_hi", hi_out, e.hi);
                    chk("sb_lo", lo_out, e.lo);
                    chk("sb_div0", {31'd0, div0_exc}, {31'd0, e.z});
                    chk("sb_timeout", {31'd0, timeout_err}, {31'd0, e.t});
                end
            end
        end
    end

    // One MULT/DIV transaction; resp=0 models a responder that never completes.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic resp,
                          input logic [31:0] rh, input logic [31:0] rl, input logic rz,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input logic et, input string nm);
        int   n_hi;
        logic ctl;
        logic ended;
        exp_t e;
        e.hi = eh; e.lo = el; e.z = ez; e.t = et;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        // Start pulse while busy, as an MTHI with a poison value: must be ignored.
        start = 1'b1; op = 2'b10; rs_val = 32'hDEADBEEF; rt_val = ~b;
        n_hi  = 0;
        ended = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (resp && cyc == lat) begin
                if (o == 2'b00) begin
                    mult_stop = 1'b1; mult_hi = rh; mult_lo = rl;
                end else begin
                    div_done = 1'b1; div_zero = rz; div_hi = rh; div_lo = rl;
                end
            end
            @(negedge clk);
            ctl = (o == 2'b00) ? mult_ctrl : div_ctrl;
            if (!ctl) begin
                chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd1);
                ended = 1'b1;
                break;
            end
            n_hi++;
            if (cyc == 2) begin
                chk({nm, "_opA_frozen"}, (o == 2'b00) ? mult_a : div_a, a);
                chk({nm, "_opB_frozen"}, (o == 2'b00) ? mult_b : div_b, b);
            end
            @(posedge clk); #1;
            start = 1'b0; mult_stop = 1'b0; div_done = 1'b0; div_zero = 1'b0;
        end
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_ctrl_stuck: got ctrl high 40 cycles expected drop", nm);
        end
        chk({nm, "_ctrl_cycles"}, 32'(n_hi), resp ? 32'(lat) : 32'd8);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // MTHI/MTLO: register updates on the sampling edge, no busy, no done.
    task automatic move_op(input logic [1:0] o, input logic [31:0] v,
                           input logic [31:0] eh, input logic [31:0] el, input string nm);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = v;
        @(negedge clk);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({nm, "_hi"}, hi_out, eh);
        chk({nm, "_lo"}, lo_out, el);
        chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        mult_stop = 1'b0; mult_hi = 32'd0; mult_lo = 32'd0;
        div_done = 1'b0; div_zero = 1'b0; div_hi = 32'd0; div_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ctrl", {30'd0, mult_ctrl, div_ctrl}, 32'd0);
        chk("rst_ops", mult_a | mult_b | div_a | div_b, 32'd0);

        run_op(2'b00, 32'd6, 32'd7, 3, 1'b1, 32'd0, 32'd42, 1'b0,
               32'd0, 32'd42, 1'b0, 1'b0, "mult_6x7");
        run_op(2'b00, 32'hFFFFFFFB, 32'd3, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, "mult_neg");
        run_op(2'b00, 32'd65536, 32'd65536, 5, 1'b1, 32'd1, 32'd0, 1'b0,
               32'd1, 32'd0, 1'b0, 1'b0, "mult_2p32");
        run_op(2'b01, 32'd23, 32'd7, 4, 1'b1, 32'd2, 32'd3, 1'b0,
               32'd2, 32'd3, 1'b0, 1'b0, "div_23_7");
        run_op(2'b01, 32'd10, 32'd0, 2, 1'b1, 32'h55555555, 32'hAAAAAAAA, 1'b1,
               32'd2, 32'd3, 1'b1, 1'b0, "div_by0");

        move_op(2'b10, 32'h00001234, 32'h00001234, 32'd3, "mthi");
        move_op(2'b11, 32'hCAFEF00D, 32'h00001234, 32'hCAFEF00D, "mtlo");

        run_op(2'b00, 32'd9, 32'd9, 0, 1'b0, 32'd0, 32'd0, 1'b0,
               32'h00001234, 32'hCAFEF00D, 1'b0, 1'b1, "mult_tmo");
        run_op(2'b01, 32'd9, 32'd2, 0, 1'b0, 32'd0, 32'd0, 1'b0,
               32'h00001234, 32'hCAFEF00D, 1'b0, 1'b1, "div_tmo");
        // Completion on the same edge as watchdog expiry: completion wins.
        run_op(2'b00, 32'd3, 32'd5, 8, 1'b1, 32'd0, 32'd15, 1'b0,
               32'd0, 32'd15, 1'b0, 1'b0, "mult_edge");

        // Reset in the middle of a DIV run.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; rs_val = 32'd100; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_div_ctrl_on", {31'd0, div_ctrl}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstrun_div_ctrl", {31'd0, div_ctrl}, 32'd0);
        chk("rstrun_busy", {31'd0, busy}, 32'd0);
        chk("rstrun_hi", hi_out, 32'd0);
        chk("rstrun_lo", lo_out, 32'd0);
        repeat (12) @(negedge clk);
        chk("rstrun_still_idle", {31'd0, busy}, 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Initiator-side sequencer between the multicycle control unit and the existing mult and div units.
- Accepts a MULT/DIV/MTHI/MTLO request and launches the arithmetic unit with stable operands.
- Holds the unit's control line until it reports completion, then captures HI/LO into architectural registers.
- Flags divide-by-zero and responder timeout to the control unit.

Parameters:
TIMEOUT_CYCLES, 80, maximum cycles in a RUN state before abort; valid range 2..255.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  request strobe from control unit, sampled only in IDLE
op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_val  in  32  operand A, or MTHI/MTLO source
rt_val  in  32  operand B
busy  out  1  high in RUN and DONE states
done  out  1  one-cycle completion pulse for MULT/DIV
div0_exc  out  1  one-cycle pulse, coincident with done, on divide by zero
timeout_err  out  1  one-cycle pulse, coincident with done, on watchdog abort
hi_out  out  32  architectural HI register
lo_out  out  32  architectural LO register
mult_ctrl  out  1  run request to mult unit
mult_a, mult_b  out  32 each  registered operands to mult unit
mult_stop  in  1  mult unit completion
mult_hi, mult_lo  in  32 each  mult result
div_ctrl  out  1  run request to div unit
div_a, div_b  out  32 each  registered operands to div unit
div_done  in  1  div unit completion
div_zero  in  1  div unit divide-by-zero flag, valid with div_done
div_hi, div_lo  in  32 each  remainder, quotient

Behaviour:
- States: IDLE, MULT_RUN, DIV_RUN, DONE.
- Reset: state IDLE. All outputs 0, including hi_out, lo_out, mult_a/b, div_a/b and the watchdog counter. Reset mid-RUN aborts immediately: ctrl lines drop on the same edge and HI/LO are cleared.
- IDLE, start=1, op=00: latch rs_val/rt_val into mult_a/mult_b, go to MULT_RUN. mult_ctrl=1 from the next cycle.
- IDLE, start=1, op=01: same, using div_a/div_b, DIV_RUN and div_ctrl.
- IDLE, start=1, op=10/11: hi_out or lo_out <= rs_val on that edge. Stay in IDLE; no busy, no done.
- RUN states:
  - ctrl held high and operands frozen.
  - Watchdog counter increments every RUN cycle, starting at 1 in the first RUN cycle.
- Completion: edge where mult_stop (or div_done) is sampled high:
  - MULT: hi_out<=mult_hi, lo_out<=mult_lo.
  - DIV with div_zero=0: hi_out<=div_hi (remainder), lo_out<=div_lo (quotient).
  - DIV with div_zero=1: HI/LO unchanged; div0_exc set for DONE.
  - In all cases ctrl drops to 0, go to DONE.
- Timeout: counter reaches TIMEOUT_CYCLES with no completion -> ctrl drops, HI/LO unchanged, timeout_err set for DONE. If completion and timeout coincide on the same edge, completion wins.
- DONE: exactly one cycle. done=1, flags as set, ctrl=0 (guarantees a low cycle so the responder re-arms). Next state IDLE; counter cleared.
- Latency: start sampled at edge 0, ctrl high during cycles 1..N, responder completion sampled at edge N, done in cycle N+1. Next start is accepted from cycle N+2.
- start while busy is ignored; op and operand inputs are don't-care outside IDLE.
- hi_out/lo_out are registered and change only at capture, at MTHI/MTLO, or at reset.
- Responder completion inputs are ignored outside their own RUN state.

Optional Feature:
HILO_FORWARD_EN
- Defined: in the completion cycle (completion input high in RUN, no div_zero), hi_out/lo_out combinationally show the incoming result. done is asserted combinationally in that same cycle, one cycle earlier. Registers still update at that edge. DONE is still entered, with done=0 during DONE, to keep the ctrl-low gap; busy drops in DONE. Error pulses keep their DONE timing.
- Undefined: fully registered outputs as above.

Test Plan:
- MULT rs=6 rt=7 -> mult_ctrl high until mult_stop; done one cycle later; hi_out=0, lo_out=42.
- MULT rs=32'hFFFFFFFB rt=3 -> hi_out=32'hFFFFFFFF, lo_out=32'hFFFFFFF1; MULT 65536*65536 -> hi_out=1, lo_out=0.
- DIV 23/7 -> lo_out=3, hi_out=2. Then DIV 10/0 -> div0_exc=1 with done, hi_out=2 and lo_out=3 retained.
- MTHI rs=32'h00001234 then MTLO rs=32'hCAFEF00D -> hi_out/lo_out update on the sampling edge; busy and done stay 0.
- Stub responder that never completes, TIMEOUT_CYCLES=8 -> ctrl high exactly 8 cycles, then timeout_err=1 and done=1 for one cycle, HI/LO unchanged.
- start pulses during MULT_RUN are ignored (operands unchanged); reset asserted mid-DIV_RUN -> next cycle div_ctrl=0, busy=0, hi_out=lo_out=0, state IDLE.
